speed_round_ctrl: RTL and testbench
===================================

SPEED_ROUND_CTRL -- requirements
Module: speed_round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_TICKS, default 5, ticks per speed round (1..255).
REQ-002 SHALL have parameter CD_TICKS, default 3, countdown ticks before each round (1..255).
REQ-003 SHALL have parameter SETTLE_CYC, default 2, clk cycles between round end and result sampling (>=2).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port tick, input, 1, one-clk-wide timebase enable.
REQ-007 SHALL have port start, input, 1, synchronous level; sampled only in IDLE or DONE.
REQ-008 SHALL have port speed_right, input, 1, right-ahead flag from the push counter.
REQ-009 SHALL have port speed_tie, input, 1, tie flag from the push counter.
REQ-010 SHALL have port speedRound, output, 1, push-counting window to the push counter.
REQ-011 SHALL have port speedExit, output, 1, one-cycle counter clear to the push counter.
REQ-012 SHALL have port pos, output, 4, rope position 0..8, centre 4.
REQ-013 SHALL have port led, output, 9, one-hot decode of pos (led[pos]=1).
REQ-014 SHALL have port win_left / win_right, output, 1 each, game-over flags.
REQ-015 SHALL have port countdown, output, 1, high during COUNTDOWN.

Function
REQ-016 SHALL implement states IDLE, COUNTDOWN, ROUND, SETTLE, MOVE, EXIT, DONE.
REQ-017 SHALL go IDLE->COUNTDOWN on start=1; DONE->COUNTDOWN on start=1, with pos reset to 4 and win flags cleared.
REQ-018 SHALL stay in COUNTDOWN for CD_TICKS tick pulses, then enter ROUND on the clk after the last counted tick.
REQ-019 SHALL hold speedRound=1 exactly while in ROUND; ROUND lasts ROUND_TICKS tick pulses.
REQ-020 SHALL spend exactly SETTLE_CYC clks in SETTLE with speedRound=0, absorbing the push counter's two-register comparison latency.
REQ-021 SHALL, in MOVE (1 clk), sample inputs: speed_tie=1 -> pos unchanged; else speed_right=1 -> pos+1; else pos-1; speed_tie has priority if both are high.
REQ-022 SHALL assert speedExit for exactly the single EXIT clk, then go to DONE if pos==8 (win_right=1) or pos==0 (win_left=1), else COUNTDOWN.
REQ-023 SHALL saturate pos within 0..8; no wrap-around.
REQ-024 SHALL ignore tick in IDLE, MOVE, EXIT, DONE; tick and start arriving together in IDLE starts the countdown without counting that tick.
REQ-025 SHALL ignore start outside IDLE/DONE.

Reset
REQ-026 SHALL on rst force IDLE, pos=4, led=9'b000010000, speedRound=0, speedExit=0, win_left=win_right=0, countdown=0, and tick counter=0.
REQ-027 SHALL treat rst mid-round as an abort: no pos update occurs and speedExit is not issued; the push counter is cleared by its own reset.

Configuration
REQ-028 SHALL support macro SUDDEN_DEATH_EN; when defined, a tie in MOVE skips COUNTDOWN after EXIT and re-enters ROUND directly.
REQ-029 SHALL, when SUDDEN_DEATH_EN is undefined, treat a tie as a normal round (EXIT->COUNTDOWN).

Structure
REQ-030 SHALL place the state enum, POS_CENTRE=4, POS_MAX=8, and position width in shared package tow_pkg.
REQ-031 SHALL use one sub-module, tick_timer: loadable down-counter decremented on tick, asserting done at zero; instanced once for COUNTDOWN and ROUND.

Verification
REQ-032 SHALL verify reset: assert rst mid-ROUND -> pos=4, led=0x010, all flags 0, state IDLE next clk.
REQ-033 SHALL verify right win: start, speed_right=1, speed_tie=0 each MOVE -> pos 5,6,7,8, win_right=1 after 4th EXIT.
REQ-034 SHALL verify timing: ROUND_TICKS=5, tick every 10 clks -> speedRound high 50 clks, MOVE exactly 2 clks after speedRound falls, speedExit 1 clk wide.
REQ-035 SHALL verify tie/priority: speed_tie=1 and speed_right=1 -> pos stays 4; with SUDDEN_DEATH_EN, countdown never asserts between rounds.
REQ-036 SHALL verify left win: pos at 1 with speed_right=0, speed_tie=0 -> pos=0, win_left=1, DONE, start ignored until DONE reached, then start returns pos to 4.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war speed-round controller: FSM states,
// rope position limits and counter widths.
package tow_pkg;

    localparam int POS_W = 4;
    localparam int CNT_W = 8;
    localparam int LED_N = 9;

    localparam logic [POS_W-1:0] POS_CENTRE = 4'd4;
    localparam logic [POS_W-1:0] POS_MAX    = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_ROUND,
        S_SETTLE,
        S_MOVE,
        S_EXIT,
        S_DONE
    } state_t;

    // One rope step from a round result; a tie outranks a right-ahead flag.
    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p,
                                                  input logic right,
                                                  input logic tie);
        logic [POS_W-1:0] r;
        r = p;
        if (tie)
            r = p;
        else if (right)
            r = (p == POS_MAX) ? p : p + POS_W'(1);
        else
            r = (p == '0) ? p : p - POS_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter stepped by timebase ticks; done is high at zero.
// Shared by the countdown and round phases of speed_round_ctrl.
module tick_timer
    import tow_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // A load on the same clk as a tick wins, so that tick is never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= value;
        else if (tick && count != '0)
            count <= count - CNT_W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/speed_round_ctrl.sv
// Speed-round sequencer for the tug-of-war game: countdown, push window,
// settle, rope move and counter clear. Define SUDDEN_DEATH_EN to replay a tied
// round straight away without a countdown.
module speed_round_ctrl
    import tow_pkg::*;
#(
    parameter int ROUND_TICKS = 5,
    parameter int CD_TICKS    = 3,
    parameter int SETTLE_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             speed_right,
    input  logic             speed_tie,
    output logic             speedRound,
    output logic             speedExit,
    output logic [POS_W-1:0] pos,
    output logic [LED_N-1:0] led,
    output logic             win_left,
    output logic             win_right,
    output logic             countdown
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC);

    state_t              state, state_next;
    logic                timer_load, timer_done, timer_tick;
    logic [CNT_W-1:0]    timer_value;
    logic [SETTLE_W-1:0] settle_cnt;
`ifdef SUDDEN_DEATH_EN
    logic                tie_seen;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = CNT_W'(CD_TICKS);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_COUNTDOWN;
                    timer_load = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (timer_done) begin
                    state_next  = S_ROUND;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(ROUND_TICKS);
                end
            end
            S_ROUND:  if (timer_done) state_next = S_SETTLE;
            S_SETTLE: if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) state_next = S_MOVE;
            S_MOVE:   state_next = S_EXIT;
            S_EXIT: begin
                if (pos == POS_MAX || pos == '0)
                    state_next = S_DONE;
`ifdef SUDDEN_DEATH_EN
                else if (tie_seen) begin
                    state_next  = S_ROUND;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(ROUND_TICKS);
                end
`endif
                else begin
                    state_next = S_COUNTDOWN;
                    timer_load = 1'b1;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        speedRound = (state == S_ROUND);
        speedExit  = (state == S_EXIT);
        countdown  = (state == S_COUNTDOWN);
        win_right  = (state == S_DONE) && (pos == POS_MAX);
        win_left   = (state == S_DONE) && (pos == '0);
        led        = '0;
        for (int i = 0; i < LED_N; i++)
            led[i] = (pos == POS_W'(i));
    end

    assign timer_tick = tick && (state == S_COUNTDOWN || state == S_ROUND);

    tick_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .value (timer_value),
        .tick  (timer_tick),
        .done  (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos        <= POS_CENTRE;
            settle_cnt <= '0;
        end else begin
            if (state == S_MOVE)
                pos <= pos_step(pos, speed_right, speed_tie);
            else if (state == S_DONE && start)
                pos <= POS_CENTRE;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
        end
    end

`ifdef SUDDEN_DEATH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tie_seen <= 1'b0;
        else if (state == S_MOVE)
            tie_seen <= speed_tie;
    end
`endif

endmodule

// File: tb/tb_speed_round_ctrl.sv
// Directed bench for speed_round_ctrl with a per-round scoreboard of expected
// rope positions; honours SUDDEN_DEATH_EN when it is defined for the build.
module tb_speed_round_ctrl;

    localparam int ROUND_TICKS = 5;
    localparam int CD_TICKS    = 3;
    localparam int SETTLE_CYC  = 2;
    localparam int TICK_DIV    = 10;
`ifdef SUDDEN_DEATH_EN
    localparam bit SD = 1'b1;
`else
    localparam bit SD = 1'b0;
`endif

    typedef struct {
        int   pos;
        logic wl;
        logic wr;
    } exp_t;

    logic       clk, rst, tick, start, speed_right, speed_tie;
    logic       speedRound, speedExit, win_left, win_right, countdown;
    logic [3:0] pos;
    logic [8:0] led;

    int   checks = 0;
    int   errors = 0;
    int   m_pos  = 4;
    exp_t sb[$];

    speed_round_ctrl #(
        .ROUND_TICKS (ROUND_TICKS),
        .CD_TICKS    (CD_TICKS),
        .SETTLE_CYC  (SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .speed_right (speed_right),
        .speed_tie   (speed_tie),
        .speedRound  (speedRound),
        .speedExit   (speedExit),
        .pos         (pos),
        .led         (led),
        .win_left    (win_left),
        .win_right   (win_right),
        .countdown   (countdown)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk tick every TICK_DIV clks, changed on the falling edge.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_round_high(input string tag);
        int n;
        n = 0;
        while (speedRound !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        check(tag, 32'(speedRound), 32'd1);
    endtask

    // Play one round with fixed push-counter flags and score the resulting move.
    task automatic run_round(input logic r, input logic t, input bit timing);
        int   hi, gap;
        exp_t e;
        speed_right = r;
        speed_tie   = t;
        if (!t) begin
            if (r && m_pos < 8) m_pos++;
            else if (!r && m_pos > 0) m_pos--;
        end
        e.pos = m_pos;
        e.wr  = (m_pos == 8);
        e.wl  = (m_pos == 0);
        sb.push_back(e);

        wait_round_high("round_start");
        hi = 0;
        while (speedRound === 1'b1 && hi < 600) begin
            step();
            hi++;
        end
        if (timing) check("round_len", 32'(hi), 32'(ROUND_TICKS * TICK_DIV));
        gap = 0;
        while (speedExit !== 1'b1 && gap < 40) begin
            step();
            gap++;
        end
        check("exit_seen", 32'(speedExit), 32'd1);
        if (timing) check("settle_gap", 32'(gap), 32'(SETTLE_CYC + 1));

        e = sb.pop_front();
        check("pos", 32'(pos), 32'(e.pos));
        check("led", 32'(led), 32'd1 << e.pos);
        step();
        check("exit_width", 32'(speedExit), 32'd0);
        check("win_right", 32'(win_right), 32'(e.wr));
        check("win_left", 32'(win_left), 32'(e.wl));
    endtask

    initial begin
        int   n, cd;
        logic bad;
        rst = 1'b1; start = 1'b0; speed_right = 1'b0; speed_tie = 1'b0;
        repeat (3) step();

        check("rst_pos", 32'(pos), 32'd4);
        check("rst_led", 32'(led), 32'h010);
        check("rst_flags", 32'({speedRound, speedExit, win_left, win_right, countdown}), 32'd0);
        rst = 1'b0;
        step();

        // Start lands on the same clk as a tick: that tick must not count.
        n = 0;
        while (tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("tick_seen", 32'(tick), 32'd1);
        repeat (TICK_DIV - 1) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("cd_enter", 32'(countdown), 32'd1);
        cd = 0;
        while (countdown === 1'b1 && cd < 200) begin
            step();
            cd++;
        end
        check("cd_len", 32'(cd), 32'(CD_TICKS * TICK_DIV + 1));

        // Right side wins in four rounds; the first also checks phase timing.
        run_round(1'b1, 1'b0, 1'b1);
        run_round(1'b1, 1'b0, 1'b0);
        run_round(1'b1, 1'b0, 1'b0);
        run_round(1'b1, 1'b0, 1'b0);
        bad = 1'b0;
        repeat (30) begin
            step();
            if (countdown !== 1'b0 || speedRound !== 1'b0 || win_right !== 1'b1 || pos !== 4'd8)
                bad = 1'b1;
        end
        check("done_hold_right", 32'(bad), 32'd0);

        // Restart from DONE, then a tie with right also high.
        start = 1'b1;
        step();
        start = 1'b0;
        m_pos = 4;
        check("restart_pos", 32'(pos), 32'd4);
        check("restart_win", 32'(win_right), 32'd0);
        check("restart_cd", 32'(countdown), 32'd1);
        run_round(1'b1, 1'b1, 1'b0);
        check("tie_next_cd", 32'(countdown), 32'(!SD));
        check("tie_next_round", 32'(speedRound), 32'(SD));

        // Start during a round is ignored.
        wait_round_high("round_for_start");
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_round", 32'(speedRound), 32'd1);
        check("start_ignored_cd", 32'(countdown), 32'd0);
        check("start_ignored_pos", 32'(pos), 32'd4);

        // Left side wins: 3, 2, 1, 0.
        run_round(1'b0, 1'b0, 1'b0);
        run_round(1'b0, 1'b0, 1'b0);
        run_round(1'b0, 1'b0, 1'b0);
        run_round(1'b0, 1'b0, 1'b0);
        bad = 1'b0;
        repeat (20) begin
            step();
            if (countdown !== 1'b0 || win_left !== 1'b1 || pos !== 4'd0)
                bad = 1'b1;
        end
        check("done_hold_left", 32'(bad), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        m_pos = 4;
        check("left_restart_pos", 32'(pos), 32'd4);
        check("left_restart_led", 32'(led), 32'h010);
        check("left_restart_win", 32'(win_left), 32'd0);
        check("left_restart_cd", 32'(countdown), 32'd1);

        // Reset in the middle of a round aborts it.
        speed_right = 1'b1;
        speed_tie   = 1'b0;
        wait_round_high("round_for_rst");
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check("abort_pos", 32'(pos), 32'd4);
        check("abort_led", 32'(led), 32'h010);
        check("abort_flags", 32'({speedRound, speedExit, win_left, win_right, countdown}), 32'd0);
        step();
        rst = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            step();
            if (countdown !== 1'b0 || speedRound !== 1'b0 || speedExit !== 1'b0 || pos !== 4'd4)
                bad = 1'b1;
        end
        check("idle_after_rst", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
